i2c_write_master: RTL

Downstream I2C write engine for the SMS motor-control datapath. Consumes the byte/strobe pair produced by the SMS decode stage (`data_out_i2c`, `load`) and serialises each byte as a single-byte I2C write (START, address+W, data, STOP) to a fixed slave, typically the PCF8574 LCD/relay expander. A one-entry pending register absorbs a `load` that arrives while a transfer is in flight.

---
 rtl/i2c_write_master_pkg.sv | 18 +
 rtl/i2c_write_master_qtr_tick.sv | 28 ++
 rtl/i2c_write_master.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_write_master_pkg.sv
// Shared types and frame constants for the i2c_write_master engine.
package i2c_write_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_ACK1  = 3'd3,
        ST_DATA  = 3'd4,
        ST_ACK2  = 3'd5,
        ST_STOP  = 3'd6
    } state_t;

    localparam int unsigned I2C_QTR_START     = 2;
    localparam int unsigned I2C_QTR_STOP      = 3;
    localparam int unsigned I2C_BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_write_master_qtr_tick.sv
// SCL quarter-period divider: counts 0..CLK_DIV-1 while enabled, pulses tick on the last count.
module i2c_qtr_tick #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_write_master.sv
// Single-byte I2C write engine (START, {SLAVE_ADDR,W}, data, STOP) with a one-entry pending byte.
// Optional `I2C_ACK_CHECK_EN: NACK on the address skips the data byte; any NACK pulses ack_err with done.
module i2c_write_master
    import i2c_write_master_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 125,
    parameter logic [6:0]  SLAVE_ADDR = 7'h27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data_in,
    input  logic       sda_i,
    output logic       scl,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       overflow
);

    localparam logic [1:0] START_LAST = 2'(I2C_QTR_START - 1);
    localparam logic [1:0] STOP_LAST  = 2'(I2C_QTR_STOP - 1);
    localparam logic [2:0] BIT_LAST   = 3'(I2C_BITS_PER_BYTE - 1);

    state_t      state, state_d;
    logic [1:0]  qtr, qtr_d;
    logic [2:0]  bit_cnt, bit_d;
    logic [15:0] sreg, sreg_d;
    logic        scl_d, sda_d, done_d, ack_err_d;
    logic        nack, nack_d;
    logic        pend_full;
    logic [7:0]  pend_byte;
    logic        tick;

    i2c_qtr_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_qtr_tick (
        .clk (clk),
        .rst (rst),
        .en  (state != ST_IDLE),
        .tick(tick)
    );

`ifndef I2C_ACK_CHECK_EN
    logic unused_sda_i;
    assign unused_sda_i = sda_i;
`endif

    // Outputs are registered and take the value of each quarter as that quarter's tick completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            qtr     <= '0;
            bit_cnt <= '0;
            sreg    <= '0;
            nack    <= 1'b0;
            scl     <= 1'b1;
            sda_oe  <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            state   <= state_d;
            qtr     <= qtr_d;
            bit_cnt <= bit_d;
            sreg    <= sreg_d;
            nack    <= nack_d;
            scl     <= scl_d;
            sda_oe  <= sda_d;
            done    <= done_d;
            ack_err <= ack_err_d;
        end
    end

    always_comb begin
        state_d   = state;
        qtr_d     = qtr;
        bit_d     = bit_cnt;
        sreg_d    = sreg;
        nack_d    = nack;
        scl_d     = scl;
        sda_d     = sda_oe;
        done_d    = 1'b0;
        ack_err_d = 1'b0;

        unique case (state)
            ST_IDLE: begin
                scl_d  = 1'b1;
                sda_d  = 1'b0;
                qtr_d  = '0;
                bit_d  = '0;
                nack_d = 1'b0;
                if (load || pend_full) begin
                    // Address and data share one shift register; data reaches the MSB after 8 address shifts.
                    sreg_d  = {SLAVE_ADDR, 1'b0, (pend_full ? pend_byte : data_in)};
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (tick) begin
                    if (qtr == 2'd0) begin
                        scl_d = 1'b1;
                        sda_d = 1'b1;
                    end else begin
                        scl_d = 1'b0;
                    end
                    if (qtr == START_LAST) begin
                        qtr_d   = '0;
                        state_d = ST_ADDR;
                    end else begin
                        qtr_d = qtr + 2'd1;
                    end
                end
            end

            ST_ADDR, ST_DATA: begin
                if (tick) begin
                    qtr_d = qtr + 2'd1;
                    unique case (qtr)
                        2'd0: begin
                            scl_d = 1'b0;
                            sda_d = ~sreg[15];
                        end
                        2'd1, 2'd2: scl_d = 1'b1;
                        default: begin
                            scl_d  = 1'b0;
                            sreg_d = {sreg[14:0], 1'b0};
                            bit_d  = bit_cnt + 3'd1;
                            if (bit_cnt == BIT_LAST) begin
                                state_d = (state == ST_ADDR) ? ST_ACK1 : ST_ACK2;
                            end
                        end
                    endcase
                end
            end

            ST_ACK1, ST_ACK2: begin
                if (tick) begin
                    qtr_d = qtr + 2'd1;
                    unique case (qtr)
                        2'd0: begin
                            scl_d = 1'b0;
                            sda_d = 1'b0;
                        end
                        2'd1: scl_d = 1'b1;
                        2'd2: begin
                            scl_d = 1'b1;
`ifdef I2C_ACK_CHECK_EN
                            nack_d = nack | sda_i;
`endif
                        end
                        default: begin
                            scl_d = 1'b0;
`ifdef I2C_ACK_CHECK_EN
                            state_d = (state == ST_ACK2 || nack) ? ST_STOP : ST_DATA;
`else
                            state_d = (state == ST_ACK2) ? ST_STOP : ST_DATA;
`endif
                        end
                    endcase
                end
            end

            ST_STOP: begin
                if (tick) begin
                    unique case (qtr)
                        2'd0: begin
                            scl_d = 1'b0;
                            sda_d = 1'b1;
                        end
                        2'd1: scl_d = 1'b1;
                        default: sda_d = 1'b0;
                    endcase
                    if (qtr == STOP_LAST) begin
                        qtr_d   = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
`ifdef I2C_ACK_CHECK_EN
                        ack_err_d = nack;
`endif
                    end else begin
                        qtr_d = qtr + 2'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Pending byte: drained by IDLE, refilled by a load in that same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_full <= 1'b0;
            pend_byte <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (state == ST_IDLE) begin
                if (pend_full) begin
                    pend_full <= load;
                    if (load) begin
                        pend_byte <= data_in;
                    end
                end
            end else if (load) begin
                if (!pend_full) begin
                    pend_full <= 1'b1;
                    pend_byte <= data_in;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign busy = (state != ST_IDLE) | pend_full;

endmodule
